// File: rtl/asym_fifo_pkg.sv
// asym_fifo_pkg: shared constant functions for the wide-write / narrow-read FIFO.
//   fifo_max / fifo_min / fifo_log2 : elaboration-time helpers
//   ratio_of / log2_ratio_of        : derive RATIO = WIDTHA/WIDTHB and its log2
//   ratio_legal                     : 1 when WIDTHA/WIDTHB is an exact power of two >= 2;
//                                     users raise an elaboration error when it returns 0
package asym_fifo_pkg;

    function automatic int unsigned fifo_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned fifo_min(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    // Ceiling log2; fifo_log2(1) = 0.
    function automatic int unsigned fifo_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        while (((32'd1 << r) < v) && (r < 31)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned ratio_of(input int unsigned wa, input int unsigned wb);
        return (wb == 0) ? 0 : wa / wb;
    endfunction

    function automatic int unsigned log2_ratio_of(input int unsigned wa, input int unsigned wb);
        return fifo_log2(ratio_of(wa, wb));
    endfunction

    function automatic bit ratio_legal(input int unsigned wa, input int unsigned wb);
        int unsigned r;
        if (wb == 0 || (wa % wb) != 0) begin
            return 1'b0;
        end
        r = wa / wb;
        return (r >= 2) && ((r & (r - 1)) == 0);
    endfunction

endpackage

// File: rtl/asym_fifo_ram.sv
// asym_fifo_ram: single-clock dual-port storage, wide write port / narrow registered read port.
// Storage is one narrow-word array of SIZEB entries; wide lane i lands at {waddr_i, i}.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (clears the read register only)
//   we_i     write enable, waddr_i wide-word address, wdata_i wide data
//   re_i     read enable, raddr_i narrow-word address
//   rdata_o  registered narrow read data, holds when re_i is low
module asym_fifo_ram
    import asym_fifo_pkg::*;
#(
    parameter int unsigned WIDTHA     = 32,
    parameter int unsigned WIDTHB     = 8,
    parameter int unsigned SIZEB      = 256,
    parameter int unsigned ADDRWIDTHA = 6,
    parameter int unsigned ADDRWIDTHB = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDRWIDTHA-1:0] waddr_i,
    input  logic [WIDTHA-1:0]     wdata_i,
    input  logic                  re_i,
    input  logic [ADDRWIDTHB-1:0] raddr_i,
    output logic [WIDTHB-1:0]     rdata_o
);

    localparam int unsigned Ratio    = ratio_of(WIDTHA, WIDTHB);
    localparam int unsigned LaneBits = fifo_max(1, log2_ratio_of(WIDTHA, WIDTHB));

    logic [WIDTHB-1:0]             mem [SIZEB];
    logic [Ratio-1:0][WIDTHB-1:0]  lanes;
    logic [WIDTHB-1:0]             rdata_q;

    // Split the wide word into narrow lanes, least-significant lane first.
    for (genvar i = 0; i < Ratio; i++) begin : g_lane
        assign lanes[i] = wdata_i[i*WIDTHB +: WIDTHB];
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < Ratio; i++) begin
                mem[{waddr_i, LaneBits'(i)}] <= lanes[LaneBits'(i)];
            end
        end
    end

    // Output register carries the reset so the array itself can map to block RAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/asym_fifo_w2n.sv
// asym_fifo_w2n: single-clock asymmetric FIFO, wide words in on port A, narrow words out on
// port B, least-significant lane first. Occupancy and flags are in narrow-word units.
// Build option: define ASYM_FIFO_ERR_EN to build the sticky overflow/underflow registers;
// otherwise both outputs are tied to 0.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset, discards all contents
//   weA, diA   write request / wide data; fullA = write not accepted this cycle
//   reB        read request; doB registered narrow data, validB = doB new this cycle
//   emptyB     no narrow word available; countB occupancy in narrow words
//   overflow   sticky: write attempted while fullA
//   underflow  sticky: read attempted while emptyB
module asym_fifo_w2n
    import asym_fifo_pkg::*;
#(
    parameter int unsigned WIDTHA     = 32,
    parameter int unsigned SIZEA      = 64,
    parameter int unsigned ADDRWIDTHA = 6,
    parameter int unsigned WIDTHB     = 8,
    parameter int unsigned SIZEB      = 256,
    parameter int unsigned ADDRWIDTHB = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  weA,
    input  logic [WIDTHA-1:0]     diA,
    output logic                  fullA,
    input  logic                  reB,
    output logic [WIDTHB-1:0]     doB,
    output logic                  validB,
    output logic                  emptyB,
    output logic [ADDRWIDTHB:0]   countB,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned RATIO     = ratio_of(WIDTHA, WIDTHB);
    localparam int unsigned LOG2RATIO = log2_ratio_of(WIDTHA, WIDTHB);

    localparam logic [ADDRWIDTHB:0] RatioCnt = (ADDRWIDTHB + 1)'(RATIO);
    localparam logic [ADDRWIDTHB:0] FullThr  = (ADDRWIDTHB + 1)'(SIZEB - RATIO);

    if (!ratio_legal(WIDTHA, WIDTHB) || (SIZEB != SIZEA * RATIO) ||
        (ADDRWIDTHB != ADDRWIDTHA + LOG2RATIO) || ((32'd1 << ADDRWIDTHA) != SIZEA))
    begin : g_param_err
        $error("asym_fifo_w2n: WIDTHA/WIDTHB must be a power of two >= 2 with consistent sizes");
    end

    logic [ADDRWIDTHA-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTHB-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTHB:0]   count_q, count_d;
    logic                  valid_q;
    logic                  full, empty, wr_acc, rd_acc;

    // Full as soon as a whole wide word no longer fits, so a partially drained slot blocks.
    assign full   = (count_q > FullThr);
    assign empty  = (count_q == '0);
    // No bypass: a read is judged against the registered count only.
    assign wr_acc = weA && !full;
    assign rd_acc = reB && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDRWIDTHA'(1);
            count_d  = count_d + RatioCnt;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDRWIDTHB'(1);
            count_d  = count_d - (ADDRWIDTHB + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= rd_acc;
        end
    end

    asym_fifo_ram #(
        .WIDTHA     (WIDTHA),
        .WIDTHB     (WIDTHB),
        .SIZEB      (SIZEB),
        .ADDRWIDTHA (ADDRWIDTHA),
        .ADDRWIDTHB (ADDRWIDTHB)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (diA),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (doB)
    );

`ifdef ASYM_FIFO_ERR_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (weA && full) begin
                ovf_q <= 1'b1;
            end
            if (reB && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign fullA  = full;
    assign emptyB = empty;
    assign countB = count_q;
    assign validB = valid_q;

endmodule

// File: tb/tb_asym_fifo_w2n.sv
// Directed bench for asym_fifo_w2n with default parameters (32-bit in, 8-bit out, 256 bytes).
module tb_asym_fifo_w2n;

`ifdef ASYM_FIFO_ERR_EN
    localparam logic ErrEn = 1'b1;
`else
    localparam logic ErrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        weA;
    logic [31:0] diA;
    logic        fullA;
    logic        reB;
    logic [7:0]  doB;
    logic        validB;
    logic        emptyB;
    logic [8:0]  countB;
    logic        overflow;
    logic        underflow;

    int n_pass  = 0;
    int n_total = 0;

    asym_fifo_w2n dut (
        .clk       (clk),
        .rst       (rst),
        .weA       (weA),
        .diA       (diA),
        .fullA     (fullA),
        .reB       (reB),
        .doB       (doB),
        .validB    (validB),
        .emptyB    (emptyB),
        .countB    (countB),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        weA = 1'b0;
        diA = '0;
        reB = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_count",  32'(countB),    32'd0);
        chk("rst_empty",  32'(emptyB),    32'd1);
        chk("rst_full",   32'(fullA),     32'd0);
        chk("rst_valid",  32'(validB),    32'd0);
        chk("rst_dob",    32'(doB),       32'd0);
        chk("rst_ovf",    32'(overflow),  32'd0);
        chk("rst_udf",    32'(underflow), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_empty", 32'(emptyB), 32'd1);

        // Single word, LSB lane first
        weA = 1'b1;
        diA = 32'h44332211;
        tick();
        weA = 1'b0;
        chk("w1_count", 32'(countB), 32'd4);
        chk("w1_empty", 32'(emptyB), 32'd0);
        w = 32'h44332211;
        reB = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("w1_valid", 32'(validB), 32'd1);
            chk("w1_dob",   32'(doB),    32'(w[8*j +: 8]));
        end
        reB = 1'b0;
        tick();
        chk("w1_valid_drop", 32'(validB), 32'd0);
        chk("w1_dob_hold",   32'(doB),    32'h44);
        chk("w1_empty_end",  32'(emptyB), 32'd1);
        chk("w1_count_end",  32'(countB), 32'd0);

        // Fill with 64 words: narrow word n carries byte n
        weA = 1'b1;
        for (int k = 0; k < 64; k++) begin
            diA = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            tick();
        end
        weA = 1'b0;
        chk("fill_count", 32'(countB), 32'd256);
        chk("fill_full",  32'(fullA),  32'd1);

        // 65th write is dropped
        weA = 1'b1;
        diA = 32'hDEADBEEF;
        tick();
        weA = 1'b0;
        chk("ovf_count", 32'(countB),   32'd256);
        chk("ovf_flag",  32'(overflow), 32'(ErrEn));

        // Three reads leave a partially drained slot: still full
        reB = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("drain3_dob", 32'(doB), 32'(n));
        end
        reB = 1'b0;
        chk("drain3_count", 32'(countB), 32'd253);
        chk("drain3_full",  32'(fullA),  32'd1);
        reB = 1'b1;
        tick();
        reB = 1'b0;
        chk("drain4_dob",   32'(doB),    32'd3);
        chk("drain4_count", 32'(countB), 32'd252);
        chk("drain4_full",  32'(fullA),  32'd0);

        // Freed slot accepts a write
        weA = 1'b1;
        diA = 32'hCAFEF00D;
        tick();
        weA = 1'b0;
        chk("refill_count", 32'(countB), 32'd256);
        chk("refill_full",  32'(fullA),  32'd1);

        // Drain everything in order, including the word written after the wrap
        reB = 1'b1;
        for (int n = 4; n < 256; n++) begin
            tick();
            chk("drain_dob", 32'(doB), 32'(n));
        end
        w = 32'hCAFEF00D;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("wrap_dob",   32'(doB),    32'(w[8*j +: 8]));
            chk("wrap_valid", 32'(validB), 32'd1);
        end
        reB = 1'b0;
        chk("drain_empty", 32'(emptyB), 32'd1);
        chk("drain_count", 32'(countB), 32'd0);
        tick();
        chk("drain_valid_drop", 32'(validB), 32'd0);

        // Simultaneous write and read at count 8
        weA = 1'b1;
        diA = 32'h13121110;
        tick();
        diA = 32'h17161514;
        tick();
        chk("sim_count8", 32'(countB), 32'd8);
        diA = 32'h1B1A1918;
        reB = 1'b1;
        tick();
        weA = 1'b0;
        chk("sim_count11", 32'(countB), 32'd11);
        chk("sim_dob",     32'(doB),    32'h10);
        for (int j = 1; j < 12; j++) begin
            tick();
            chk("sim_order", 32'(doB), 32'h10 + 32'(j));
        end
        reB = 1'b0;
        chk("sim_empty", 32'(emptyB), 32'd1);

        // Read on empty
        reB = 1'b1;
        tick();
        chk("udf_valid", 32'(validB),    32'd0);
        chk("udf_flag",  32'(underflow), 32'(ErrEn));
        chk("udf_dob",   32'(doB),       32'h1B);
        chk("udf_count", 32'(countB),    32'd0);

        // Read in the same cycle as the first write: no bypass
        weA = 1'b1;
        diA = 32'h0;
        tick();
        weA = 1'b0;
        reB = 1'b0;
        chk("nobyp_valid", 32'(validB),    32'd0);
        chk("nobyp_count", 32'(countB),    32'd4);
        chk("nobyp_udf",   32'(underflow), 32'(ErrEn));

        // Bring count to 100 and reset mid-stream
        weA = 1'b1;
        for (int k = 0; k < 24; k++) begin
            diA = 32'h5A5A5A5A;
            tick();
        end
        weA = 1'b0;
        chk("pre_rst_count", 32'(countB), 32'd100);
        reB = 1'b1;
        tick();
        reB = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", 32'(countB),    32'd0);
        chk("mid_rst_empty", 32'(emptyB),    32'd1);
        chk("mid_rst_valid", 32'(validB),    32'd0);
        chk("mid_rst_dob",   32'(doB),       32'd0);
        chk("mid_rst_ovf",   32'(overflow),  32'd0);
        chk("mid_rst_udf",   32'(underflow), 32'd0);
        chk("mid_rst_full",  32'(fullA),     32'd0);

        // Fresh data after reset
        weA = 1'b1;
        diA = 32'h87654321;
        tick();
        weA = 1'b0;
        reB = 1'b1;
        tick();
        reB = 1'b0;
        chk("post_rst_dob",   32'(doB),    32'h21);
        chk("post_rst_valid", 32'(validB), 32'd1);
        chk("post_rst_count", 32'(countB), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/asym_fifo_w2n.md
# asym_fifo_w2n

Single-clock asymmetric FIFO that accepts wide words on port A and returns them as a stream of narrow words on port B, least-significant lane first. It is the width-down counterpart of the team's narrow-write/wide-read asymmetric RAM. It serves packed 32-bit producers that feed byte-oriented consumers. Storage is inferable block RAM; flags and occupancy are maintained in narrow-word units.

## Interface
Parameters:
- WIDTHA, 32, write word width
- SIZEA, 64, depth in wide words
- ADDRWIDTHA, 6, log2(SIZEA)
- WIDTHB, 8, read word width; WIDTHA must be WIDTHB × 2^k, k≥1
- SIZEB, 256, depth in narrow words (= SIZEA × RATIO)
- ADDRWIDTHB, 8, log2(SIZEB)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- weA  in  1  write request
- diA  in  WIDTHA  write data
- fullA  out  1  write not accepted this cycle
- reB  in  1  read request
- doB  out  WIDTHB  read data, registered
- validB  out  1  doB holds a new word this cycle
- emptyB  out  1  no narrow word available
- countB  out  ADDRWIDTHB+1  occupancy in narrow words
- overflow  out  1  sticky: write attempted while fullA
- underflow  out  1  sticky: read attempted while emptyB

## Operation
- RATIO = WIDTHA/WIDTHB. Write pointer: ADDRWIDTHA bits, wide units. Read pointer: ADDRWIDTHB bits, narrow units. Both pointers wrap naturally mod depth.
- Write accepted when weA && !fullA. diA lane i (bits [(i+1)·WIDTHB-1 : i·WIDTHB]) goes to narrow address {wr_ptr, i}.
- Read accepted when reB && !emptyB. The narrow word at rd_ptr is registered into doB, and rd_ptr increments by 1.
- Count update: +RATIO on accepted write, −1 on accepted read. Both in one cycle gives +RATIO−1.
- fullA = (countB > SIZEB − RATIO). A partially drained wide slot blocks a write until all its lanes are read.
- emptyB = (countB == 0). Both flags are combinational from the registered count.
- No write-to-read bypass. A read in the same cycle as the first write into an empty FIFO is rejected, and underflow is set if enabled.
- Rejected requests change no state except the sticky error flags.
- Reset values: pointers 0, countB 0, emptyB 1, fullA 0, validB 0, doB 0, overflow 0, underflow 0.
- rst asserted mid-stream discards all contents. The FIFO is empty at the first edge after rst is released.

## Timing
- Write at edge N: emptyB falls and countB reflects the write after edge N. The earliest read is accepted at edge N+1.
- Read at edge N: doB and validB are valid after edge N. validB is 1 for exactly one cycle per accepted read. doB holds its value while validB is 0.
- Back-to-back reads sustain 1 narrow word/cycle. Back-to-back writes sustain 1 wide word/cycle until full.
- fullA deasserts the cycle after the read that brings countB to SIZEB − RATIO.

## Configuration
- ASYM_FIFO_ERR_EN defined: overflow and underflow are sticky and cleared only by rst.
- ASYM_FIFO_ERR_EN undefined: the error registers are not built, and overflow and underflow are tied to 0. All other behaviour is identical.

## Structure
- Package asym_fifo_pkg holds:
  - the max, min and log2 constant functions
  - RATIO and log2RATIO derivation
  - the parameter legality check, which causes an elaboration error when WIDTHA/WIDTHB is not a power of two ≥2.
- Sub-module asym_fifo_ram holds the storage:
  - a 1-clock dual-port RAM, wide write and narrow registered read
  - narrow-word array of SIZEB entries
  - generate-for per-lane write.
- Pointers, count, flags and validB live in the top module.

## Test plan
- Reset, then write 0x44332211 and read 4 times → doB = 0x11, 0x22, 0x33, 0x44 with validB each cycle; emptyB=1 afterwards, countB=0.
- Write 64 words without reading → fullA=1 at countB=256. A 65th write is dropped and sets overflow. Reading 256 words returns the data in order.
- Fill to 256, read 3 words → fullA stays 1. Read a 4th → fullA=0 next cycle, and the next write is accepted.
- Simultaneous write and read at countB=8 → countB=11. The data order is preserved across the pointer wrap after more than 64 writes.
- Read on empty, and read in the same cycle as the first write → validB=0, underflow=1, countB=4 afterwards.
- Assert rst with countB=100 → countB=0, emptyB=1, validB=0, flags cleared. The following write/read pair returns the new data.
